// File: rtl/byte_bus_pkg.sv
// Shared types and helpers for the byte-masked memory bus demultiplexer.
package byte_bus_pkg;

  localparam int unsigned MAX_ADDR_W = 64;
  localparam int unsigned MAX_MEMS   = 16;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] base;
    logic [MAX_ADDR_W-1:0] mask;
  } region_t;

  function automatic int unsigned sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic region_hit(region_t r, logic [MAX_ADDR_W-1:0] addr);
    return (addr & r.mask) == (r.base & r.mask);
  endfunction

endpackage

// File: rtl/byte_addr_decode.sv
// Base+mask region decoder: lowest-index hitting region wins, no hit means unmapped.
module byte_addr_decode
  import byte_bus_pkg::*;
#(
  parameter int unsigned               MEMS      = 4,
  parameter int unsigned               ADDR_SIZE = 32,
  parameter logic [MEMS*ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter logic [MEMS*ADDR_SIZE-1:0] ADDR_MASK = '0,
  parameter int unsigned               SEL_W     = sel_width(MEMS)
) (
  input  logic [ADDR_SIZE-1:0] addr,
  output logic [MEMS-1:0]      onehot,
  output logic [SEL_W-1:0]     idx,
  output logic                 unmapped
);

  function automatic region_t region_at(int unsigned i);
    region_t r;
    r.base = MAX_ADDR_W'(BASE_ADDR[i*ADDR_SIZE +: ADDR_SIZE]);
    r.mask = MAX_ADDR_W'(ADDR_MASK[i*ADDR_SIZE +: ADDR_SIZE]);
    return r;
  endfunction

  logic [MAX_ADDR_W-1:0] addr_x;
  logic                  found;

  always_comb addr_x = MAX_ADDR_W'(addr);

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < MEMS; i++) begin
      if (!found && region_hit(region_at(i), addr_x)) begin
        onehot[i] = 1'b1;
        idx       = SEL_W'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb unmapped = ~found;

endmodule

// File: rtl/byte_demux_n.sv
// N-way demux for the byte-masked memory bus with region decode, read-return
// routing, unmapped-access error capture and an optional request slot.
module byte_demux_n
  import byte_bus_pkg::*;
#(
  parameter int unsigned               MEMS      = 4,
  parameter int unsigned               DATA_BYTE = 4,
  parameter int unsigned               ADDR_SIZE = 32,
  parameter logic [MEMS*ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter logic [MEMS*ADDR_SIZE-1:0] ADDR_MASK = '0,
  parameter bit                        REG_REQ   = 1'b0,
  parameter logic [31:0]               ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          useEnable_i,
  input  logic                          useIsWrite_i,
  input  logic [DATA_BYTE-1:0]          useWriteMask_i,
  input  logic [ADDR_SIZE-1:0]          useAddr_i,
  input  logic [DATA_BYTE*8-1:0]        useWriteData_i,
  output logic [DATA_BYTE*8-1:0]        useReadData_o,
  output logic                          useHold_o,
  output logic [MEMS-1:0]               memEnable_o,
  output logic [MEMS-1:0]               memIsWrite_o,
  output logic [MEMS*DATA_BYTE-1:0]     memWriteMask_o,
  output logic [MEMS*ADDR_SIZE-1:0]     memAddr_o,
  output logic [MEMS*DATA_BYTE*8-1:0]   memWriteData_o,
  input  logic [MEMS*DATA_BYTE*8-1:0]   memReadData_i,
  input  logic [MEMS-1:0]               memHold_i,
  output logic                          errValid_o,
  output logic [ADDR_SIZE-1:0]          errAddr_o,
  output logic                          errIsWrite_o,
  input  logic                          errClear_i
);

  localparam int unsigned SEL_W = sel_width(MEMS);
  localparam int unsigned DW    = DATA_BYTE * 8;

  function automatic logic [DW-1:0] err_fill();
    logic [DW-1:0] w;
    for (int unsigned i = 0; i < DW; i++) w[i] = ERR_DATA[i % 32];
    return w;
  endfunction

  localparam logic [DW-1:0] ERR_WORD = err_fill();

  logic [MEMS-1:0]      dec_onehot;
  logic [SEL_W-1:0]     dec_idx;
  logic                 dec_unmapped;

  logic                 iss_en;
  logic                 iss_w;
  logic [DATA_BYTE-1:0] iss_mask;
  logic [ADDR_SIZE-1:0] iss_addr;
  logic [DW-1:0]        iss_data;
  logic [MEMS-1:0]      iss_onehot;
  logic [SEL_W-1:0]     iss_idx;
  logic                 iss_unmapped;

  logic                 sel_hold;
  logic                 tgt_acc;
  logic                 err_new;

  logic                 ret_pend_q;
  logic                 ret_err_q;
  logic [SEL_W-1:0]     sel_q;

  byte_addr_decode #(
    .MEMS      (MEMS),
    .ADDR_SIZE (ADDR_SIZE),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK),
    .SEL_W     (SEL_W)
  ) u_decode (
    .addr     (useAddr_i),
    .onehot   (dec_onehot),
    .idx      (dec_idx),
    .unmapped (dec_unmapped)
  );

  generate
    if (REG_REQ) begin : g_slot
      logic                 valid_q;
      logic                 w_q;
      logic [DATA_BYTE-1:0] mask_q;
      logic [ADDR_SIZE-1:0] addr_q;
      logic [DW-1:0]        data_q;
      logic [MEMS-1:0]      onehot_q;
      logic [SEL_W-1:0]     idx_q;
      logic                 unmapped_q;

      // The slot refills (or empties) exactly when the master sees no hold,
      // so the target side is fed only from registers.
      always_ff @(posedge clk_i) begin
        if (rst_i)           valid_q <= 1'b0;
        else if (!useHold_o) valid_q <= useEnable_i;
      end

      always_ff @(posedge clk_i) begin
        if (!useHold_o) begin
          w_q        <= useIsWrite_i;
          mask_q     <= useWriteMask_i;
          addr_q     <= useAddr_i;
          data_q     <= useWriteData_i;
          onehot_q   <= dec_onehot;
          idx_q      <= dec_idx;
          unmapped_q <= dec_unmapped;
        end
      end

      always_comb begin
        iss_en       = valid_q;
        iss_w        = w_q;
        iss_mask     = mask_q;
        iss_addr     = addr_q;
        iss_data     = data_q;
        iss_onehot   = onehot_q;
        iss_idx      = idx_q;
        iss_unmapped = unmapped_q;
      end
    end else begin : g_comb
      always_comb begin
        iss_en       = useEnable_i;
        iss_w        = useIsWrite_i;
        iss_mask     = useWriteMask_i;
        iss_addr     = useAddr_i;
        iss_data     = useWriteData_i;
        iss_onehot   = dec_onehot;
        iss_idx      = dec_idx;
        iss_unmapped = dec_unmapped;
      end
    end
  endgenerate

  always_comb begin
    memEnable_o    = iss_en ? iss_onehot : '0;
    memIsWrite_o   = {MEMS{iss_w}};
    memWriteMask_o = {MEMS{iss_mask}};
    memAddr_o      = {MEMS{iss_addr}};
    memWriteData_o = {MEMS{iss_data}};
  end

  always_comb begin
    sel_hold  = ~iss_unmapped & memHold_i[iss_idx];
    useHold_o = iss_en & sel_hold;
    tgt_acc   = iss_en & ~sel_hold;
    err_new   = tgt_acc & iss_unmapped & (~errValid_o | errClear_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ret_pend_q <= 1'b0;
      ret_err_q  <= 1'b0;
      sel_q      <= '0;
    end else begin
      ret_pend_q <= tgt_acc & ~iss_w;
      if (tgt_acc && !iss_w) begin
        ret_err_q <= iss_unmapped;
        sel_q     <= iss_idx;
      end
    end
  end

  always_comb begin
    useReadData_o = '0;
    if (ret_pend_q) useReadData_o = ret_err_q ? ERR_WORD : memReadData_i[sel_q*DW +: DW];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      errValid_o   <= 1'b0;
      errAddr_o    <= '0;
      errIsWrite_o <= 1'b0;
    end else if (err_new) begin
      errValid_o   <= 1'b1;
      errAddr_o    <= iss_addr;
      errIsWrite_o <= iss_w;
    end else if (errClear_i) begin
      errValid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_demux_n.sv
// Randomised bench for byte_demux_n: both request-path variants against a transaction-level model.
module tb_byte_demux_n;

  localparam int unsigned MEMS      = 4;
  localparam int unsigned DATA_BYTE = 4;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned DW        = 32;
  localparam logic [MEMS*ADDR_SIZE-1:0] BASES =
    {32'h2000_0000, 32'h8000_0000, 32'h1000_0000, 32'h8000_0000};
  localparam logic [MEMS*ADDR_SIZE-1:0] MASKS =
    {32'hF000_0000, 32'h8000_0000, 32'hF000_0000, 32'hC000_0000};
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  logic [31:0] ref_base [4] = '{32'h8000_0000, 32'h1000_0000, 32'h8000_0000, 32'h2000_0000};
  logic [31:0] ref_mask [4] = '{32'hC000_0000, 32'hF000_0000, 32'h8000_0000, 32'hF000_0000};

  typedef struct {
    logic        w;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data;
    int          tgt;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic u_en = 1'b0, u_w = 1'b0, clr = 1'b0;
  logic [3:0]  u_mask = '0;
  logic [31:0] u_addr = '0, u_data = '0;
  logic [MEMS*DW-1:0] rd_in = '0;
  logic [MEMS-1:0]    hold_in = '0;

  logic [DW-1:0] rdata0, rdata1;
  logic hold0, hold1, ev0, ev1, ew0, ew1;
  logic [MEMS-1:0] en0, en1, w0, w1;
  logic [MEMS*DATA_BYTE-1:0] mk0, mk1;
  logic [MEMS*ADDR_SIZE-1:0] ad0, ad1;
  logic [MEMS*DW-1:0] wd0, wd1;
  logic [31:0] ea0, ea1;

  int   n_vec = 0;
  int   n_err = 0;
  int   mode = 0;
  logic m_rst = 1'b0, m_en = 1'b0, m_w = 1'b0, m_clr = 1'b0;
  logic [3:0]  m_mask = '0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic fix_rd = 1'b0;
  int unsigned hold_pct = 0;
  int   hold_cnt [4] = '{0, 0, 0, 0};
  logic [31:0] rd_now [4];

  req_t slotq [$];
  logic up_acc = 1'b0, exp_ret = 1'b0, fresh = 1'b1;
  int   exp_ret_tgt = -1;
  logic exp_ev = 1'b0, exp_ew = 1'b0;
  logic [31:0] exp_ea = '0;

  always #5 clk = ~clk;

  byte_demux_n #(
    .MEMS(MEMS), .DATA_BYTE(DATA_BYTE), .ADDR_SIZE(ADDR_SIZE),
    .BASE_ADDR(BASES), .ADDR_MASK(MASKS), .REG_REQ(1'b0), .ERR_DATA(ERR_DATA)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .useEnable_i(u_en), .useIsWrite_i(u_w),
    .useWriteMask_i(u_mask), .useAddr_i(u_addr), .useWriteData_i(u_data),
    .useReadData_o(rdata0), .useHold_o(hold0), .memEnable_o(en0), .memIsWrite_o(w0),
    .memWriteMask_o(mk0), .memAddr_o(ad0), .memWriteData_o(wd0),
    .memReadData_i(rd_in), .memHold_i(hold_in),
    .errValid_o(ev0), .errAddr_o(ea0), .errIsWrite_o(ew0), .errClear_i(clr)
  );

  byte_demux_n #(
    .MEMS(MEMS), .DATA_BYTE(DATA_BYTE), .ADDR_SIZE(ADDR_SIZE),
    .BASE_ADDR(BASES), .ADDR_MASK(MASKS), .REG_REQ(1'b1), .ERR_DATA(ERR_DATA)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .useEnable_i(u_en), .useIsWrite_i(u_w),
    .useWriteMask_i(u_mask), .useAddr_i(u_addr), .useWriteData_i(u_data),
    .useReadData_o(rdata1), .useHold_o(hold1), .memEnable_o(en1), .memIsWrite_o(w1),
    .memWriteMask_o(mk1), .memAddr_o(ad1), .memWriteData_o(wd1),
    .memReadData_i(rd_in), .memHold_i(hold_in),
    .errValid_o(ev1), .errAddr_o(ea1), .errIsWrite_o(ew1), .errClear_i(clr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (REG_REQ=%0d) t=%0t: got %h expected %h", tag, mode, $time, got, exp);
    end
  endtask

  function automatic int ref_target(logic [31:0] a);
    int r = -1;
    for (int i = 3; i >= 0; i--)
      if ((a & ref_mask[i]) == (ref_base[i] & ref_mask[i])) r = i;
    return r;
  endfunction

  // Compare this cycle's outputs with the model, then advance the model past the next edge.
  task automatic evaluate();
    logic [MEMS-1:0] o_en, o_w, exp_en;
    logic [MEMS*4-1:0] o_mk;
    logic [MEMS*32-1:0] o_ad, o_wd;
    logic [31:0] o_rd, o_ea;
    logic o_hold, o_ev, o_ew, have, held, tacc;
    req_t cur;
    o_en = mode != 0 ? en1 : en0;       o_w  = mode != 0 ? w1 : w0;
    o_mk = mode != 0 ? mk1 : mk0;       o_ad = mode != 0 ? ad1 : ad0;
    o_wd = mode != 0 ? wd1 : wd0;       o_rd = mode != 0 ? rdata1 : rdata0;
    o_hold = mode != 0 ? hold1 : hold0; o_ev = mode != 0 ? ev1 : ev0;
    o_ea = mode != 0 ? ea1 : ea0;       o_ew = mode != 0 ? ew1 : ew0;
    cur = '{1'b0, 4'h0, 32'h0, 32'h0, -1};
    if (mode == 0) begin
      have = u_en;
      cur  = '{u_w, u_mask, u_addr, u_data, ref_target(u_addr)};
    end else begin
      have = slotq.size() != 0;
      if (have) cur = slotq[0];
    end
    held   = have && cur.tgt >= 0 && hold_in[cur.tgt];
    exp_en = '0;
    if (have && cur.tgt >= 0) exp_en[cur.tgt] = 1'b1;
    check_eq("mem_enable", 64'(o_en), 64'(exp_en));
    check_eq("use_hold", 64'(o_hold), 64'(held));
    if (have && cur.tgt >= 0) begin
      check_eq("mem_addr", 64'(o_ad[cur.tgt*32 +: 32]), 64'(cur.addr));
      check_eq("mem_is_write", 64'(o_w[cur.tgt]), 64'(cur.w));
      if (cur.w) begin
        check_eq("mem_mask", 64'(o_mk[cur.tgt*4 +: 4]), 64'(cur.mask));
        check_eq("mem_wdata", 64'(o_wd[cur.tgt*32 +: 32]), 64'(cur.data));
      end
    end
    if (exp_ret)
      check_eq("read_data", 64'(o_rd), 64'(exp_ret_tgt < 0 ? ERR_DATA : rd_now[exp_ret_tgt]));
    else if (fresh)
      check_eq("read_data_after_reset", 64'(o_rd), 64'd0);
    check_eq("err_valid", 64'(o_ev), 64'(exp_ev));
    if (exp_ev || fresh) begin
      check_eq("err_addr", 64'(o_ea), 64'(exp_ea));
      check_eq("err_is_write", 64'(o_ew), 64'(exp_ew));
    end

    if (rst) begin
      slotq.delete();
      up_acc = 1'b0; exp_ret = 1'b0; fresh = 1'b1;
      exp_ev = 1'b0; exp_ea = '0; exp_ew = 1'b0;
    end else begin
      tacc   = have && !held;
      up_acc = u_en && !held;
      if (tacc && cur.tgt < 0 && (!exp_ev || clr)) begin
        exp_ev = 1'b1; exp_ea = cur.addr; exp_ew = cur.w;
      end else if (clr) begin
        exp_ev = 1'b0;
      end
      exp_ret     = tacc && !cur.w;
      exp_ret_tgt = cur.tgt;
      if (exp_ret) fresh = 1'b0;
      if (mode != 0) begin
        if (tacc) void'(slotq.pop_front());
        if (up_acc) slotq.push_back('{u_w, u_mask, u_addr, u_data, ref_target(u_addr)});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst = m_rst; u_en = m_en; u_w = m_w; u_mask = m_mask;
    u_addr = m_addr; u_data = m_data; clr = m_clr;
    for (int t = 0; t < 4; t++) begin
      rd_now[t] = fix_rd ? (32'h0234_5678 | (32'(t) << 28)) : $urandom;
      rd_in[t*32 +: 32] = rd_now[t];
      if (hold_cnt[t] > 0) begin
        hold_in[t] = 1'b1;
        hold_cnt[t]--;
      end else begin
        hold_in[t] = (hold_pct != 0) && ($urandom_range(99) < hold_pct);
      end
    end
    @(negedge clk);
    evaluate();
  endtask

  task automatic issue(input logic w, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data);
    int n = 0;
    m_en = 1'b1; m_w = w; m_addr = addr; m_mask = mask; m_data = data;
    do begin
      tick();
      n++;
    end while (!up_acc && n < 40);
    if (!up_acc) check_eq("accept_timeout", 64'(up_acc), 64'd1);
    m_en = 1'b0;
  endtask

  task automatic idle(input int n);
    m_en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    m_rst = 1'b1; m_en = 1'b0; m_clr = 1'b0;
    tick();
    m_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    for (int md = 0; md < 2; md++) begin
      mode = md;
      hold_pct = 0; fix_rd = 1'b1;
      do_reset();
      idle(2);
      issue(1'b0, 32'h1000_0004, 4'hF, 32'h0);
      idle(3);
      issue(1'b0, 32'h8000_0000, 4'hF, 32'h0);
      idle(3);
      hold_cnt[2] = 3;
      issue(1'b1, 32'hC000_0040, 4'h5, 32'hA5A5_0F0F);
      idle(5);
      issue(1'b0, 32'h0000_0010, 4'hF, 32'h0);
      idle(3);
      issue(1'b1, 32'h0000_0020, 4'h3, 32'h1111_2222);
      idle(3);
      check_eq("err_first_addr", 64'(mode != 0 ? ea1 : ea0), 64'h10);
      m_clr = 1'b1; tick(); m_clr = 1'b0;
      idle(2);
      fix_rd = 1'b0;
      for (int i = 0; i < 8; i++)
        issue(1'b0, (i % 2 == 0) ? 32'h8000_0000 + 32'(i*4) : 32'h2000_0000 + 32'(i*4), 4'hF, 32'h0);
      idle(3);

      hold_pct = 25;
      for (int n = 0; n < 300; n++) begin
        if (!(u_en && !up_acc)) begin
          m_en   = $urandom_range(99) < 75;
          m_w    = 1'($urandom_range(1));
          m_addr = {4'($urandom_range(15)), 28'($urandom)};
          m_mask = 4'($urandom);
          m_data = $urandom;
        end
        m_clr = $urandom_range(99) < 5;
        tick();
      end
      m_clr = 1'b0; hold_pct = 0;
      idle(3);

      // Reset while a request is parked at a holding target.
      issue(1'b0, 32'h0000_0030, 4'hF, 32'h0);
      hold_cnt[2] = 12;
      issue(1'b1, 32'hE000_0000, 4'hF, 32'h5555_AAAA);
      tick();
      do_reset();
      hold_cnt[2] = 0;
      idle(3);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
